ps2_ql_keymatrix: RTL

//  PS/2 keyboard front end for the ZX8302/IPC keyboard scan. Receives the PS/2 kbd stream from the
//  io-controller link, decodes make/break/extended codes and keeps a QL-style 8x8 key matrix.
//  The IPC side scans the matrix with a row-select mask. Sits between the user_io PS/2 pins and zx8302.

---
 rtl/ql_kbd_pkg.sv | 39 +++
 rtl/ps2_ql_keymatrix_if.sv | 15 +
 rtl/ps2_ql_keymap.sv | 100 ++++++++++
 rtl/ps2_ql_keymatrix.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ql_kbd_pkg.sv
// ql_kbd_pkg: shared constants and types for the PS/2 -> QL key matrix front end.
//   - PS/2 prefix codes (extended, break, pause) and the discard-code check
//   - rx_state_t: receiver states {IDLE, SHIFT, CHECK}
//   - keymap_entry_t: one keymap ROM word {vld, row, col}
package ql_kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Pause sends E1 followed by seven more bytes that carry no key state.
    localparam int PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] row;
        logic [2:0] col;
    } keymap_entry_t;

    // Self-test / ack / resend / echo / overrun codes: never key data.
    function automatic logic is_discard(input logic [7:0] code);
        return code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    function automatic keymap_entry_t km(input logic [2:0] row, input logic [2:0] col);
        keymap_entry_t e;
        e.vld = 1'b1;
        e.row = row;
        e.col = col;
        return e;
    endfunction

endpackage

// File: rtl/ps2_ql_keymatrix_if.sv
// ps2_ql_keymatrix_if: IPC-side matrix scan bus.
//   row_sel   : active-high row scan mask (driven by the scanner)
//   col_out   : OR of selected matrix rows
//   any_key   : any matrix bit set
//   key_event : one-cycle pulse on a matrix change
// master = scanner (IPC/zx8302), slave = key matrix.
interface ps2_ql_keymatrix_if;
    logic [7:0] row_sel;
    logic [7:0] col_out;
    logic       any_key;
    logic       key_event;

    modport master (output row_sel, input col_out, input any_key, input key_event);
    modport slave  (input row_sel, output col_out, output any_key, output key_event);
endinterface

// File: rtl/ps2_ql_keymap.sv
// ps2_ql_keymap: 512x7 synchronous keymap ROM indexed by {ext, scancode}.
// Ports:
//   clk   in  : clock
//   addr  in  : {ext, code}
//   entry out : registered {vld, row, col}, valid one clock after addr
// Shift/Ctrl/Alt sit on row 7 (c0/c1/c2); the remaining keys follow the QL layout.
module ps2_ql_keymap
    import ql_kbd_pkg::*;
(
    input  logic          clk,
    input  logic [8:0]    addr,
    output keymap_entry_t entry
);

    function automatic keymap_entry_t decode(input logic [8:0] a);
        keymap_entry_t e;
        e = '0;
        case (a)
            // row 0: F4 F1 5 F2 F3 F5 4 7
            9'h00C: e = km(3'd0, 3'd0);
            9'h005: e = km(3'd0, 3'd1);
            9'h02E: e = km(3'd0, 3'd2);
            9'h006: e = km(3'd0, 3'd3);
            9'h004: e = km(3'd0, 3'd4);
            9'h003: e = km(3'd0, 3'd5);
            9'h025: e = km(3'd0, 3'd6);
            9'h03D: e = km(3'd0, 3'd7);
            // row 1: Enter Left Up Esc Right \ Space Down
            9'h05A: e = km(3'd1, 3'd0);
            9'h16B: e = km(3'd1, 3'd1);
            9'h171: e = km(3'd1, 3'd1);   // Delete acts as Left (QL Ctrl-Left deletes)
            9'h175: e = km(3'd1, 3'd2);
            9'h076: e = km(3'd1, 3'd3);
            9'h174: e = km(3'd1, 3'd4);
            9'h05D: e = km(3'd1, 3'd5);
            9'h029: e = km(3'd1, 3'd6);
            9'h172: e = km(3'd1, 3'd7);
            // row 2: ] Z . C B - M '
            9'h05B: e = km(3'd2, 3'd0);
            9'h01A: e = km(3'd2, 3'd1);
            9'h049: e = km(3'd2, 3'd2);
            9'h021: e = km(3'd2, 3'd3);
            9'h032: e = km(3'd2, 3'd4);
            9'h03A: e = km(3'd2, 3'd6);
            9'h052: e = km(3'd2, 3'd7);
            // row 3: [ Caps K S F = G ;
            9'h054: e = km(3'd3, 3'd0);
            9'h058: e = km(3'd3, 3'd1);
            9'h042: e = km(3'd3, 3'd2);
            9'h01B: e = km(3'd3, 3'd3);
            9'h02B: e = km(3'd3, 3'd4);
            9'h055: e = km(3'd3, 3'd5);
            9'h034: e = km(3'd3, 3'd6);
            9'h04C: e = km(3'd3, 3'd7);
            // row 4: L 3 H 1 A P D J
            9'h04B: e = km(3'd4, 3'd0);
            9'h026: e = km(3'd4, 3'd1);
            9'h033: e = km(3'd4, 3'd2);
            9'h016: e = km(3'd4, 3'd3);
            9'h01C: e = km(3'd4, 3'd4);
            9'h04D: e = km(3'd4, 3'd5);
            9'h023: e = km(3'd4, 3'd6);
            9'h03B: e = km(3'd4, 3'd7);
            // row 5: 9 W I Tab R - Y O
            9'h046: e = km(3'd5, 3'd0);
            9'h01D: e = km(3'd5, 3'd1);
            9'h043: e = km(3'd5, 3'd2);
            9'h00D: e = km(3'd5, 3'd3);
            9'h02D: e = km(3'd5, 3'd4);
            9'h04E: e = km(3'd5, 3'd5);
            9'h035: e = km(3'd5, 3'd6);
            9'h044: e = km(3'd5, 3'd7);
            // row 6: 8 2 6 Q E 0 T U
            9'h03E: e = km(3'd6, 3'd0);
            9'h01E: e = km(3'd6, 3'd1);
            9'h036: e = km(3'd6, 3'd2);
            9'h015: e = km(3'd6, 3'd3);
            9'h024: e = km(3'd6, 3'd4);
            9'h045: e = km(3'd6, 3'd5);
            9'h02C: e = km(3'd6, 3'd6);
            9'h03C: e = km(3'd6, 3'd7);
            // row 7: Shift Ctrl Alt X V / N ,
            9'h012, 9'h059: e = km(3'd7, 3'd0);
            9'h014, 9'h114: e = km(3'd7, 3'd1);
            9'h011, 9'h111: e = km(3'd7, 3'd2);
            9'h022: e = km(3'd7, 3'd3);
            9'h02A: e = km(3'd7, 3'd4);
            9'h04A: e = km(3'd7, 3'd5);
            9'h031: e = km(3'd7, 3'd6);
            9'h041: e = km(3'd7, 3'd7);
            default: e = '0;
        endcase
        return e;
    endfunction

    always_ff @(posedge clk) begin
        entry <= decode(addr);
    end

endmodule

// File: rtl/ps2_ql_keymatrix.sv
// ps2_ql_keymatrix: PS/2 keyboard receiver, scancode decoder and QL 8x8 key matrix.
// Ports:
//   clk        in  : bus clock
//   reset      in  : synchronous, active-high
//   ps2_clk    in  : PS/2 clock (asynchronous, input only)
//   ps2_data   in  : PS/2 data (asynchronous, input only)
//   scan       if  : slave side of the row_sel/col_out/any_key/key_event scan bus
//   err_cnt    out : saturating count of bad or timed-out frames
//   reset_req  out : Ctrl-Alt-Del request
// Build option KBD_CAD_RESET_EN: when defined, E0 71 (Delete) drives a shadow bit
// instead of the matrix and reset_req = Ctrl & Alt & Delete; otherwise reset_req = 0.
//
// state | meaning
// IDLE  | waiting for a start bit (data low on a PS/2 clock fall)
// SHIFT | shifting in 8 data bits, parity and stop, LSB first
// CHECK | one cycle: validate parity/stop, hand byte to decoder
module ps2_ql_keymatrix
    import ql_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2625,
    parameter int ERR_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_ql_keymatrix_if.slave  scan,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               reset_req
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_CHECK = CHECK;

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    // Synchronisers reset to the idle-high line level so no false edge follows reset.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];

    logic [1:0]       rx_state;
    logic [9:0]       shreg;
    logic [3:0]       bit_cnt;
    logic [TMR_W-1:0] tmr;
    logic             frame_ok;
    logic             frame_bad;
    logic             timeout;
    logic [7:0]       code;

    assign code      = shreg[7:0];
    assign frame_ok  = (rx_state == ST_CHECK) && (^shreg[8:0]) && shreg[9];
    assign frame_bad = (rx_state == ST_CHECK) && !frame_ok;
    assign timeout   = (rx_state == ST_SHIFT) && !fall && (tmr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tmr      <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (fall && !data_sync[1]) begin
                        rx_state <= ST_SHIFT;
                        bit_cnt  <= '0;
                        tmr      <= TMR_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        shreg   <= {data_sync[1], shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        tmr     <= TMR_LOAD;
                        if (bit_cnt == 4'd9)
                            rx_state <= ST_CHECK;
                    end else if (tmr == '0) begin
                        rx_state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_CHECK: rx_state <= ST_IDLE;
                default:  rx_state <= ST_IDLE;
            endcase
        end
    end

    logic            ext;
    logic            brk;
    logic [2:0]      skip_cnt;
    logic            lkp_pend;
    logic            to_matrix;
    logic [7:0][7:0] matrix;
    logic            key_event_q;
    keymap_entry_t   rom_q;

    // ROM address tracks the shift register; it is stable for the lookup cycle
    // because the next frame cannot complete that soon.
    ps2_ql_keymap u_keymap (
        .clk   (clk),
        .addr  ({ext, code}),
        .entry (rom_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            skip_cnt    <= '0;
            lkp_pend    <= 1'b0;
            matrix      <= '0;
            key_event_q <= 1'b0;
            err_cnt     <= '0;
        end else begin
            key_event_q <= 1'b0;
            lkp_pend    <= 1'b0;

            if ((frame_bad || timeout) && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            // Prefix flags survive frame errors, so an F0 followed by a bad frame keeps brk.
            if (frame_ok) begin
                if (skip_cnt != '0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (code == SC_EXT) begin
                    ext <= 1'b1;
                end else if (code == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (code == SC_PAUSE) begin
                    skip_cnt <= 3'(PAUSE_SKIP);
                end else if (is_discard(code)) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    lkp_pend <= 1'b1;
                end
            end

            if (lkp_pend) begin
                ext <= 1'b0;
                brk <= 1'b0;
                // Only a real transition updates the bit: covers typematic repeat
                // and breaks of keys that were never made.
                if (rom_q.vld && to_matrix && (matrix[rom_q.row][rom_q.col] == brk)) begin
                    matrix[rom_q.row][rom_q.col] <= !brk;
                    key_event_q                  <= 1'b1;
                end
            end
        end
    end

`ifdef KBD_CAD_RESET_EN
    localparam logic [7:0] SC_DEL = 8'h71;

    logic lkp_del;
    logic del_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            lkp_del   <= 1'b0;
            del_held  <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            if (frame_ok)
                lkp_del <= ext && (code == SC_DEL);
            if (lkp_pend && lkp_del)
                del_held <= !brk;
            reset_req <= matrix[7][1] & matrix[7][2] & del_held;
        end
    end

    assign to_matrix = !lkp_del;
`else
    assign reset_req = 1'b0;
    assign to_matrix = 1'b1;
`endif

    logic [7:0] col_nxt;

    always_comb begin
        col_nxt = '0;
        for (int r = 0; r < 8; r++) begin
            if (scan.row_sel[r])
                col_nxt = col_nxt | matrix[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan.col_out <= '0;
            scan.any_key <= 1'b0;
        end else begin
            scan.col_out <= col_nxt;
            scan.any_key <= |matrix;
        end
    end

    assign scan.key_event = key_event_q;

endmodule
